// File: rtl/vga_fb_arbiter.sv
// Round-robin arbiter for the frame-buffer write port; writes are only granted while the display blanks.
// Define FB_ARB_VBLANK_ONLY_EN to restrict the write window to vertical blanking.
module vga_fb_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 16,
    parameter int HBLANK_MAX = 160
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 vga_valid,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*10-1:0]  req_x,
    input  logic [N_REQ*10-1:0]  req_y,
    input  logic [N_REQ*16-1:0]  req_rgb,
    output logic [N_REQ-1:0]     gnt,
    output logic                 fb_we,
    output logic [9:0]           fb_x,
    output logic [9:0]           fb_y,
    output logic [15:0]          fb_rgb,
    output logic                 window
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(HBLANK_MAX + 2);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_next;
    logic [PW-1:0] owner, owner_next;
    logic [PW-1:0] rr_ptr, rr_ptr_next;
    logic [BW-1:0] burst_cnt, burst_cnt_next;
    logic [CW-1:0] blank_cnt, blank_cnt_next;
    logic          window_next;
    logic          xfer;
    logic [PW:0]   cand;
    logic [PW:0]   inc;
    logic [PW-1:0] pick;
    logic [PW-1:0] owner_inc;
    logic [9:0]    sel_x, sel_y;
    logic [15:0]   sel_rgb;

    // Blank-run length saturates one past the longest hblank, so "> HBLANK_MAX" means vblank.
    always_comb begin
        blank_cnt_next = blank_cnt;
        if (vga_valid)
            blank_cnt_next = '0;
        else if (blank_cnt != CW'(HBLANK_MAX + 1))
            blank_cnt_next = blank_cnt + CW'(1);
`ifdef FB_ARB_VBLANK_ONLY_EN
        window_next = (blank_cnt_next > CW'(HBLANK_MAX));
`else
        window_next = (blank_cnt_next != '0);
`endif
    end

    always_comb begin
        gnt = '0;
        if (state == BURST)
            gnt[owner] = req[owner] & window;
    end

    assign xfer = |(req & gnt);

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_rgb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == PW'(i)) begin
                sel_x   = req_x[10*i +: 10];
                sel_y   = req_y[10*i +: 10];
                sel_rgb = req_rgb[16*i +: 16];
            end
        end
    end

    // Scanning downward lets the requester nearest rr_ptr win without a found flag.
    always_comb begin
        pick = rr_ptr;
        cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ))
                cand = cand - (PW+1)'(N_REQ);
            if (req[cand[PW-1:0]])
                pick = cand[PW-1:0];
        end
        inc       = {1'b0, owner} + (PW+1)'(1);
        owner_inc = (inc == (PW+1)'(N_REQ)) ? '0 : inc[PW-1:0];
    end

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        rr_ptr_next    = rr_ptr;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (window && (|req)) begin
                    owner_next     = pick;
                    burst_cnt_next = '0;
                    state_next     = BURST;
                end
            end
            BURST: begin
                if (xfer)
                    burst_cnt_next = burst_cnt + BW'(1);
                if (!req[owner] || !window ||
                    (xfer && (burst_cnt == BW'(MAX_BURST - 1)))) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            blank_cnt <= '0;
            window    <= 1'b0;
            fb_we     <= 1'b0;
            fb_x      <= '0;
            fb_y      <= '0;
            fb_rgb    <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            rr_ptr    <= rr_ptr_next;
            burst_cnt <= burst_cnt_next;
            blank_cnt <= blank_cnt_next;
            window    <= window_next;
            fb_we     <= xfer;
            if (xfer) begin
                fb_x   <= sel_x;
                fb_y   <= sel_y;
                fb_rgb <= sel_rgb;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter; follows FB_ARB_VBLANK_ONLY_EN when defined.
module tb_vga_fb_arbiter;

    localparam int N_REQ      = 4;
    localparam int MAX_BURST  = 16;
    localparam int HBLANK_MAX = 160;
`ifdef FB_ARB_VBLANK_ONLY_EN
    localparam int WIN_LAG = HBLANK_MAX + 1;
`else
    localparam int WIN_LAG = 1;
`endif

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         vga_valid;
    logic [3:0]   req;
    logic [39:0]  req_x;
    logic [39:0]  req_y;
    logic [63:0]  req_rgb;
    logic [3:0]   gnt;
    logic         fb_we;
    logic [9:0]   fb_x;
    logic [9:0]   fb_y;
    logic [15:0]  fb_rgb;
    logic         window;

    int checks   = 0;
    int failures = 0;

    vga_fb_arbiter #(
        .N_REQ(N_REQ),
        .MAX_BURST(MAX_BURST),
        .HBLANK_MAX(HBLANK_MAX)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .vga_valid(vga_valid),
        .req(req),
        .req_x(req_x),
        .req_y(req_y),
        .req_rgb(req_rgb),
        .gnt(gnt),
        .fb_we(fb_we),
        .fb_x(fb_x),
        .fb_y(fb_y),
        .fb_rgb(fb_rgb),
        .window(window)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] r);
        vga_valid = valid;
        req       = r;
    endtask

    // Every sample and input change happens on the falling edge.
    task automatic stepCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic doReset(input logic valid, input logic [3:0] r);
        applyStimulus(valid, r);
        sys_rst = 1'b1;
        stepCycles(3);
        sys_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          we_cnt;
        int          first;
        logic [3:0]  exp_gnt;
        logic [3:0]  prev_gnt;

        // Fixed per-slot data: slot 2 carries the single-write vector.
        req_x   = {10'd639, 10'd5,  10'd300, 10'd100};
        req_y   = {10'd479, 10'd7,  10'd400, 10'd200};
        req_rgb = {16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

        // Test 1: reset with every requester asking during blanking
        sys_rst = 1'b1;
        applyStimulus(1'b0, 4'b1111);
        stepCycles(3);
        checkOutput("t1_gnt", gnt, 0);
        checkOutput("t1_we", fb_we, 0);
        checkOutput("t1_window", window, 0);
        checkOutput("t1_x", fb_x, 0);
        checkOutput("t1_y", fb_y, 0);
        checkOutput("t1_rgb", fb_rgb, 0);
        sys_rst = 1'b0;
        applyStimulus(1'b1, 4'b0000);
        stepCycles(2);

        // Test 2: single write from requester 2
        applyStimulus(1'b0, 4'b0100);
        stepCycles(WIN_LAG);
        checkOutput("t2_window", window, 1);
        checkOutput("t2_arb_gnt", gnt, 0);
        stepCycles(1);
        checkOutput("t2_gnt", gnt, 4'b0100);
        stepCycles(1);
        checkOutput("t2_we", fb_we, 1);
        checkOutput("t2_x", fb_x, 5);
        checkOutput("t2_y", fb_y, 7);
        checkOutput("t2_rgb", fb_rgb, 16'hF800);
        applyStimulus(1'b0, 4'b0000);
        stepCycles(1);
        checkOutput("t2_we_off", fb_we, 0);
        checkOutput("t2_x_hold", fb_x, 5);
        checkOutput("t2_gnt_off", gnt, 0);

        // Test 3: all four requesting, owners 0,1,2,3,0 each for a full burst
        doReset(1'b0, 4'b1111);
        stepCycles(WIN_LAG);
        prev_gnt = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j <= MAX_BURST; j++) begin
                exp_gnt = (j == 0) ? 4'b0000 : (4'b0001 << (k % 4));
                checkOutput("t3_gnt", gnt, exp_gnt);
                checkOutput("t3_we", fb_we, (prev_gnt != 4'b0000));
                prev_gnt = exp_gnt;
                stepCycles(1);
            end
        end

        // Test 4: owner 1 cut off when active video returns
        checkOutput("t4_arb", gnt, 0);
        we_cnt = 0;
        for (int s = 1; s <= 5; s++) begin
            stepCycles(1);
            checkOutput("t4_gnt", gnt, 4'b0010);
            if (fb_we) we_cnt++;
        end
        applyStimulus(1'b1, 4'b1111);
        stepCycles(1);
        checkOutput("t4_gnt_drop", gnt, 0);
        checkOutput("t4_window", window, 0);
        checkOutput("t4_x", fb_x, 300);
        if (fb_we) we_cnt++;
        stepCycles(1);
        if (fb_we) we_cnt++;
        checkOutput("t4_xfers", we_cnt, 5);
        stepCycles(3);
        applyStimulus(1'b0, 4'b1111);
        stepCycles(WIN_LAG);
        checkOutput("t4_arb2", gnt, 0);
        stepCycles(1);
        checkOutput("t4_next_owner", gnt, 4'b0100);

        // Test 5: latency from blank start to first grant
        doReset(1'b1, 4'b0001);
`ifdef FB_ARB_VBLANK_ONLY_EN
        applyStimulus(1'b0, 4'b0001);
        we_cnt = 0;
        for (int n = 0; n < HBLANK_MAX; n++) begin
            stepCycles(1);
            if ((gnt != 4'b0000) || window) we_cnt++;
        end
        checkOutput("t5_hblank_quiet", we_cnt, 0);
        applyStimulus(1'b1, 4'b0001);
        stepCycles(2);
`endif
        applyStimulus(1'b0, 4'b0001);
        first = 0;
        for (int n = 1; n <= 300 && first == 0; n++) begin
            stepCycles(1);
            if (gnt != 4'b0000) first = n;
        end
        checkOutput("t5_first_gnt", first, WIN_LAG + 1);

        // Test 6: requester 0 drops after three transfers
        doReset(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        stepCycles(WIN_LAG);
        we_cnt = 0;
        for (int g = 1; g <= 4; g++) begin
            stepCycles(1);
            checkOutput("t6_gnt", gnt, 4'b0001);
            if (fb_we) we_cnt++;
        end
        applyStimulus(1'b0, 4'b1010);
        stepCycles(1);
        checkOutput("t6_gnt_off", gnt, 0);
        if (fb_we) we_cnt++;
        stepCycles(1);
        if (fb_we) we_cnt++;
        checkOutput("t6_xfers", we_cnt, 3);
        checkOutput("t6_next_owner", gnt, 4'b0010);

        // Test 7: reset mid-burst clears a registered write
        stepCycles(1);
        checkOutput("t7_pre_we", fb_we, 1);
        checkOutput("t7_pre_x", fb_x, 300);
        sys_rst = 1'b1;
        stepCycles(1);
        checkOutput("t7_we", fb_we, 0);
        checkOutput("t7_x", fb_x, 0);
        checkOutput("t7_gnt", gnt, 0);
        sys_rst = 1'b0;
        stepCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
